// File: rtl/alu_seq_nbit.sv
// Registered N-bit ALU with valid/ready handshakes; shifts run one bit per cycle.
// Define ALU_MUL_EN to compile in the iterative shift-add multiplier for OP 111.
module alu_seq_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic             CF,
    output logic             SF,
    output logic             ZF,
    output logic             OF
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
`ifdef ALU_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b111;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_work;
    logic [2:0]       r_op;
    logic [CW-1:0]    r_cnt;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH:0]   w_mulSum;
    logic [WIDTH-1:0] w_stHi;
`endif

    logic [WIDTH-1:0] r_res;
    logic             r_cf;
    logic             r_sf;
    logic             r_zf;
    logic             r_of;

    logic             w_accept;
    logic             w_multi;
    logic [SW-1:0]    w_k;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_imRes;
    logic             w_imCf;
    logic             w_imOf;
    logic [WIDTH-1:0] w_stWork;
    logic             w_stCf;
    logic             w_lastStep;
    logic             w_loadIm;
    logic             w_loadSt;
    logic [WIDTH-1:0] w_newRes;
    logic             w_newCf;
    logic             w_newOf;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign R  = r_res;
    assign CF = r_cf;
    assign SF = r_sf;
    assign ZF = r_zf;
    assign OF = r_of;

    assign w_accept   = in_valid && (r_state == IDLE);
    assign w_k        = B[SW-1:0];
    assign w_sum      = {1'b0, A} + {1'b0, B};
    assign w_diff     = {1'b0, A} - {1'b0, B};
    assign w_lastStep = (r_state == BUSY) && (r_cnt == CW'(1));
    assign w_loadIm   = w_accept && !w_multi;
    assign w_loadSt   = w_lastStep;

    always_comb begin
        w_multi = 1'b0;
        if ((OP == OP_SHL || OP == OP_SHR) && (w_k != '0)) begin
            w_multi = 1'b1;
        end
`ifdef ALU_MUL_EN
        if (OP == OP_MUL) begin
            w_multi = 1'b1;
        end
`endif
    end

    // Results of everything that completes on the accepting edge, including zero-length shifts.
    always_comb begin
        w_imRes = '0;
        w_imCf  = 1'b0;
        w_imOf  = 1'b0;
        case (OP)
            OP_ADD: begin
                w_imRes = w_sum[WIDTH-1:0];
                w_imCf  = w_sum[WIDTH];
                w_imOf  = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_imRes = w_diff[WIDTH-1:0];
                w_imCf  = w_diff[WIDTH];
                w_imOf  = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SHL, OP_SHR: w_imRes = A;
            OP_AND:         w_imRes = A & B;
            OP_OR:          w_imRes = A | B;
            OP_XOR:         w_imRes = A ^ B;
            default: begin
                w_imRes = '0;
                w_imCf  = 1'b0;
                w_imOf  = 1'b0;
            end
        endcase
    end

    // One iteration of the multi-cycle datapath; the multiplier keeps {hi, lo} as a
    // double-width product that is shifted right after each conditional add.
    always_comb begin
        w_stWork = r_work;
        w_stCf   = 1'b0;
`ifdef ALU_MUL_EN
        w_mulSum = {1'b0, r_hi} + (r_work[0] ? {1'b0, r_b} : '0);
        w_stHi   = r_hi;
`endif
        case (r_op)
            OP_SHL: begin
                w_stWork = {r_work[WIDTH-2:0], 1'b0};
                w_stCf   = r_work[WIDTH-1];
            end
            OP_SHR: begin
                w_stWork = {1'b0, r_work[WIDTH-1:1]};
                w_stCf   = r_work[0];
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
                w_stWork = {w_mulSum[0], r_work[WIDTH-1:1]};
                w_stHi   = w_mulSum[WIDTH:1];
                w_stCf   = |w_mulSum[WIDTH:1];
            end
`endif
            default: begin
                w_stWork = r_work;
                w_stCf   = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_newRes = w_loadIm ? w_imRes : w_stWork;
        w_newCf  = w_loadIm ? w_imCf  : w_stCf;
        w_newOf  = w_loadIm ? w_imOf  : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = w_multi ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (w_lastStep) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
            r_op   <= '0;
            r_cnt  <= '0;
`ifdef ALU_MUL_EN
            r_b    <= '0;
            r_hi   <= '0;
`endif
        end else if (w_accept) begin
            r_work <= A;
            r_op   <= OP;
            r_cnt  <= {1'b0, w_k};
`ifdef ALU_MUL_EN
            r_b    <= B;
            r_hi   <= '0;
            if (OP == OP_MUL) begin
                r_cnt <= CW'(WIDTH);
            end
`endif
        end else if (r_state == BUSY) begin
            r_work <= w_stWork;
            r_cnt  <= r_cnt - CW'(1);
`ifdef ALU_MUL_EN
            r_hi   <= w_stHi;
`endif
        end
    end

    // Visible result and flags change only when DONE is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= '0;
            r_cf  <= 1'b0;
            r_sf  <= 1'b0;
            r_zf  <= 1'b1;
            r_of  <= 1'b0;
        end else if (w_loadIm || w_loadSt) begin
            r_res <= w_newRes;
            r_cf  <= w_newCf;
            r_sf  <= w_newRes[WIDTH-1];
            r_zf  <= (w_newRes == '0);
            r_of  <= w_newOf;
        end
    end

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Self-checking bench for alu_seq_nbit: directed literal cases plus random traffic
// checked every cycle against a due-time behavioural model.
module tb_alu_seq_nbit;

    localparam int WIDTH = 8;
    localparam int FULL  = 1 << WIDTH;
    localparam int HALF  = 1 << (WIDTH - 1);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       OP;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] R;
    logic             CF;
    logic             SF;
    logic             ZF;
    logic             OF;

    int total = 0;
    int bad   = 0;
    bit checkEn = 0;

    typedef struct packed {
        int r;
        bit cf;
        bit of;
        int extra;
    } res_t;

    alu_seq_nbit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .OP        (OP),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R),
        .CF        (CF),
        .SF        (SF),
        .ZF        (ZF),
        .OF        (OF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int toSigned(int v);
        return (v >= HALF) ? v - FULL : v;
    endfunction

    // Arithmetic definition of every operation and of its extra latency in cycles.
    function automatic res_t calc(int a, int b, int op);
        res_t res;
        int   k;
        int   s;
        longint p;
        res.r = 0; res.cf = 0; res.of = 0; res.extra = 0;
        k = b % WIDTH;
        case (op)
            0: begin
                s = a + b;
                res.r  = s % FULL;
                res.cf = (s >= FULL);
                s = toSigned(a) + toSigned(b);
                res.of = (s >= HALF) || (s < -HALF);
            end
            1: begin
                res.r  = (a - b + FULL) % FULL;
                res.cf = (a < b);
                s = toSigned(a) - toSigned(b);
                res.of = (s >= HALF) || (s < -HALF);
            end
            2: begin
                res.r  = (a << k) % FULL;
                res.cf = (k != 0) ? ((a >> (WIDTH - k)) & 1) : 0;
                res.extra = k;
            end
            3: begin
                res.r  = a >> k;
                res.cf = (k != 0) ? ((a >> (k - 1)) & 1) : 0;
                res.extra = k;
            end
            4: res.r = a & b;
            5: res.r = a | b;
            6: res.r = a ^ b;
            default: begin
`ifdef ALU_MUL_EN
                p = longint'(a) * longint'(b);
                res.r  = int'(p % FULL);
                res.cf = (p >= FULL);
                res.extra = WIDTH;
`else
                p = 0;
                res.r = int'(p);
`endif
            end
        endcase
        return res;
    endfunction

    // Model: one outstanding op with the cycle from which its result becomes visible.
    int   cyc   = 0;
    int   mDue  = 0;
    bit   mBusy = 0;
    res_t pend;
    int   heldR  = 0;
    bit   heldCf = 0;
    bit   heldOf = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy  <= 0;
            heldR  <= 0;
            heldCf <= 0;
            heldOf <= 0;
        end else begin
            if (mBusy && cyc >= mDue && out_ready) begin
                mBusy  <= 0;
                heldR  <= pend.r;
                heldCf <= pend.cf;
                heldOf <= pend.of;
            end else if (!mBusy && in_valid) begin
                pend  <= calc(int'(A), int'(B), int'(OP));
                mDue  <= cyc + 1 + calc(int'(A), int'(B), int'(OP)).extra;
                mBusy <= 1;
            end
            cyc <= cyc + 1;
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            int  expR;
            bit  expValid;
            expValid = mBusy && (cyc >= mDue);
            expR     = expValid ? pend.r : heldR;
            checkOutput("in_ready",  int'(in_ready),  int'(!mBusy));
            checkOutput("out_valid", int'(out_valid), int'(expValid));
            checkOutput("R",  int'(R),  expR);
            checkOutput("CF", int'(CF), int'(expValid ? pend.cf : heldCf));
            checkOutput("OF", int'(OF), int'(expValid ? pend.of : heldOf));
            checkOutput("SF", int'(SF), (expR >> (WIDTH - 1)) & 1);
            checkOutput("ZF", int'(ZF), int'(expR == 0));
        end
    end

    task automatic applyStimulus();
        @(negedge clk);
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        A  = WIDTH'($urandom);
        B  = WIDTH'($urandom);
        OP = 3'($urandom_range(0, 7));
    endtask

    task automatic scramble();
        in_valid = 1'($urandom_range(0, 1));
        A  = WIDTH'($urandom);
        B  = WIDTH'($urandom);
        OP = 3'($urandom_range(0, 7));
    endtask

    task automatic runOp(input string name, input int a, input int b, input int op,
                         input int eR, input int eCf, input int eSf, input int eZf,
                         input int eOf, input int eLat, input int hold);
        int lat;
        @(negedge clk);
        A = WIDTH'(a); B = WIDTH'(b); OP = 3'(op);
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            scramble();
            @(negedge clk);
            lat++;
        end
        checkOutput({name, "_lat"}, lat, eLat);
        checkOutput({name, "_R"},  int'(R),  eR);
        checkOutput({name, "_CF"}, int'(CF), eCf);
        checkOutput({name, "_SF"}, int'(SF), eSf);
        checkOutput({name, "_ZF"}, int'(ZF), eZf);
        checkOutput({name, "_OF"}, int'(OF), eOf);
        for (int i = 0; i < hold; i++) begin
            scramble();
            @(negedge clk);
            checkOutput({name, "_holdR"}, int'(R), eR);
            checkOutput({name, "_holdCF"}, int'(CF), eCf);
            checkOutput({name, "_holdReady"}, int'(in_ready), 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({name, "_readyBack"}, int'(in_ready), 1);
        checkOutput({name, "_validDrop"}, int'(out_valid), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; OP = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_R", int'(R), 0);
        checkOutput("rst_ZF", int'(ZF), 1);
        checkOutput("rst_in_ready", int'(in_ready), 1);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        #2 rst_n = 1'b1;
        checkEn = 1;

        runOp("add",    200, 100, 0, 44,   1, 0, 0, 0, 1, 0);
        runOp("sub",    5,   7,   1, 8'hFE, 1, 1, 0, 0, 1, 0);
        runOp("subOv",  8'h80, 1, 1, 8'h7F, 0, 0, 0, 1, 1, 0);
        runOp("shl",    8'hA1, 3, 2, 8'h08, 1, 0, 0, 0, 4, 0);
        runOp("shr0",   8'h05, 0, 3, 8'h05, 0, 0, 0, 0, 1, 0);
        runOp("xor",    8'h3C, 8'h3C, 6, 0, 0, 0, 1, 0, 1, 0);
`ifdef ALU_MUL_EN
        runOp("mul",    15, 20, 7, 8'h2C, 1, 0, 0, 0, 9, 0);
`else
        runOp("mul",    15, 20, 7, 0, 0, 0, 1, 0, 1, 0);
`endif
        runOp("bkpr",   8'h7F, 1, 0, 8'h80, 0, 1, 0, 1, 1, 5);

        // Reset in the middle of a long op: nothing may emerge afterwards.
        @(negedge clk);
`ifdef ALU_MUL_EN
        A = 8'd15; B = 8'd20; OP = 3'd7;
`else
        A = 8'hFF; B = 8'd7; OP = 3'd2;
`endif
        in_valid = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midRst_out_valid", int'(out_valid), 0);
        checkOutput("midRst_in_ready", int'(in_ready), 1);
        checkOutput("midRst_R", int'(R), 0);
        checkOutput("midRst_ZF", int'(ZF), 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checkOutput("noStaleValid", int'(out_valid), 0);
        end
        runOp("addAfterRst", 1, 1, 0, 2, 0, 0, 0, 0, 1, 0);

        repeat (3000) applyStimulus();
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("drain_idle", int'(in_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_nbit.md
# alu_seq_nbit

Parametrised, registered successor to the 3-bit combinational ALU, adding multi-cycle shift and multiply operations. Operands are accepted through a valid/ready input handshake. The result and flags are returned through a valid/ready output handshake. The block sits between the operand-fetch stage and the result write-back stage, and processes one operation at a time.

## Interface
Parameters:
- WIDTH, 8, operand/result width; must be a power of 2, at least 4.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand request valid
- in_ready  out  1  block can accept a request
- A  in  WIDTH  operand A (unsigned, also read as two's complement for SF/OF)
- B  in  WIDTH  operand B
- OP  in  3  000 ADD, 001 SUB, 010 SHL, 011 SHR, 100 AND, 101 OR, 110 XOR, 111 MUL
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- R  out  WIDTH  result
- CF  out  1  carry / borrow / shifted-out bit / multiply high-half nonzero
- SF  out  1  R[WIDTH-1]
- ZF  out  1  R == 0
- OF  out  1  signed overflow (ADD/SUB only, else 0)

## Operation
- FSM states: IDLE, BUSY, DONE.
- in_ready = 1 only in IDLE. A transfer occurs when in_valid && in_ready; A, B and OP are latched on that edge.
- IDLE to DONE: for ADD, SUB, AND, OR, XOR, and for shifts with amount 0.
- IDLE to BUSY: for shifts with amount k > 0, and for MUL.
- BUSY to DONE: when the iteration counter expires.
- DONE to IDLE: on out_ready.
- ADD: R = (A+B) mod 2^WIDTH; CF = carry out; OF = signed overflow.
- SUB: R = (A-B) mod 2^WIDTH; CF = 1 iff A < B unsigned (borrow); OF = signed overflow.
- SHL/SHR: amount k = B[$clog2(WIDTH)-1:0]; upper bits of B are ignored. Shifts are logical, one bit per BUSY cycle. CF = last bit shifted out; CF = 0 when k = 0.
- AND/OR/XOR: bitwise; CF = 0.
- MUL: unsigned shift-add, one partial product per BUSY cycle, WIDTH cycles in total. R = low WIDTH bits of the product; CF = 1 iff the high WIDTH bits are nonzero.
- SF and ZF are derived from the final R for every OP. OF = 0 for every OP except ADD/SUB.
- R, CF, SF, ZF and OF are registered. They update only on entry to DONE and hold until the next DONE entry.

## Timing
- Request accepted at edge N. out_valid rises at:
  - N+1 for single-cycle ops and k = 0 shifts
  - N+1+k for shifts
  - N+1+WIDTH for MUL
- out_valid = 1 exactly in DONE.
- While out_valid && !out_ready, R and all flags are held stable for any number of cycles.
- in_ready returns high the cycle after the out_ready handshake. Back-to-back throughput is 1 op per 2 cycles minimum.
- in_valid is ignored outside IDLE; A, B and OP may change freely while BUSY or DONE.
- Reset, asserted at any time including mid-BUSY:
  - state IDLE; any in-flight op is discarded with no output
  - in_ready = 1
  - out_valid = 0
  - R = 0
  - CF = SF = OF = 0
  - ZF = 1
- Reset release: the first transfer is possible on the first rising edge with rst_n high.

## Configuration
- ALU_MUL_EN defined: OP 111 performs MUL as specified, and the shift-add datapath is compiled in.
- ALU_MUL_EN undefined: no multiply datapath is compiled in. OP 111 behaves as a single-cycle op with R = 0, CF = OF = SF = 0, ZF = 1, and out_valid at N+1.

## Test plan
- WIDTH=8, ADD A=200 B=100 -> R=44, CF=1, ZF=0, SF=0, OF=0, out_valid at N+1.
- SUB A=5 B=7 -> R=0xFE, CF=1, SF=1, OF=0. Then SUB A=0x80 B=0x01 -> R=0x7F, OF=1, CF=0.
- SHL A=0xA1 B=3 -> R=0x08, CF=1, out_valid at N+4. Then SHR A=0x05 B=0 -> R=0x05, CF=0, out_valid at N+1.
- MUL (ALU_MUL_EN defined) A=15 B=20 -> R=0x2C, CF=1, out_valid at N+9. Without the macro: R=0, ZF=1, out_valid at N+1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while toggling A/B/OP/in_valid -> R/flags stable, in_ready=0 throughout. Then out_ready=1 -> in_ready=1 on the next cycle.
- Assert rst_n=0 during MUL BUSY (cycle N+4) -> out_valid=0, R=0, ZF=1, in_ready=1 immediately. No result appears after release; the next ADD 1+1 returns R=2.
